// File: rtl/otbn_pq_bf_seq.sv
// -----------------------------------------------------------------------------
// otbn_pq_bf_seq
//
// Butterfly issue sequencer for post-quantum NTT kernels. A start pulse
// launches a run of 1..8 butterflies on the 32-bit lanes of a 256-bit WDR.
// Each butterfly is presented to the ALU writeback stage as one operation with
// a valid/ready handshake. The operation carries the operand and destination
// lane selects, the ALU op vector for the transform flavour (Cooley-Tukey or
// Gentleman-Sande) and the twiddle-ROM index. The twiddle index advances by a
// programmable stride per accepted butterfly and wraps modulo 2^TwIdxW.
//
// Ports
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   start_i        one-cycle launch pulse (acted on only in IDLE)
//   mode_i         0 = Cooley-Tukey, 1 = Gentleman-Sande (sampled at start)
//   num_bf_i       butterflies to issue, legal range 1..8 (sampled at start)
//   tw_base_i      first twiddle index (sampled at start)
//   tw_stride_i    twiddle-index increment per butterfly (sampled at start)
//   clear_i        synchronous abort, wins over start and handshake
//   issue_valid_o  an ALU operation is presented
//   issue_ready_i  writeback accepts the presented operation
//   a_sel_o        operand_a lane select
//   b_sel_o        operand_b lane select
//   d_sel_o        destination lane select
//   op_o           ALU op vector (8'h34 CT, 8'h92 GS, 8'h00 when idle)
//   tw_idx_o       twiddle-ROM index of the current butterfly
//   busy_o         a sequence is in progress (ISSUE or DONE)
//   done_o         one-cycle pulse when the sequence completes
//   err_o          one-cycle pulse for an illegal start (num_bf_i 0 or > 8)
//   stall_cnt_o    (only with OTBN_PQ_BF_SEQ_STALL_CNT_EN) saturating count of
//                  cycles with issue_valid_o=1 and issue_ready_i=0, cleared at
//                  every accepted start
//
// Configuration
//   `define OTBN_PQ_BF_SEQ_STALL_CNT_EN adds the stall_cnt_o port and counter.
//
// Parameters
//   TwIdxW    twiddle-index width
//   NumLanes  32-bit lanes per WDR; only 8 is supported (3-bit selects)
// -----------------------------------------------------------------------------
module otbn_pq_bf_seq #(
  parameter int unsigned TwIdxW   = 8,
  parameter int unsigned NumLanes = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic [3:0]        num_bf_i,
  input  logic [TwIdxW-1:0] tw_base_i,
  input  logic [TwIdxW-1:0] tw_stride_i,
  input  logic              clear_i,
  output logic              issue_valid_o,
  input  logic              issue_ready_i,
  output logic [2:0]        a_sel_o,
  output logic [2:0]        b_sel_o,
  output logic [2:0]        d_sel_o,
  output logic [7:0]        op_o,
  output logic [TwIdxW-1:0] tw_idx_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
`ifdef OTBN_PQ_BF_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt_o
`endif
);

  // ALU op vectors for the two butterfly flavours.
  localparam logic [7:0] OpCt   = 8'h34;
  localparam logic [7:0] OpGs   = 8'h92;
  localparam logic [7:0] OpNone = 8'h00;

  // Largest legal butterfly count: one butterfly per lane.
  localparam logic [3:0] MaxBf = 4'(NumLanes);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StDone  = 2'd2
  } state_e;

  state_e            state;
  logic              mode_q;      // latched flavour, 1 = GS
  logic [3:0]        count_q;     // latched butterfly count, 1..8
  logic [TwIdxW-1:0] stride_q;    // latched twiddle stride
  logic [2:0]        lane_q;      // lane of the butterfly being presented
  logic [TwIdxW-1:0] tw_idx_q;    // twiddle index of that butterfly

  // Combinational helpers feeding the sequential block.
  logic              start_legal;
  logic              handshake;
  logic              last_bf;
  logic [2:0]        lane_nxt;
  logic [TwIdxW-1:0] tw_idx_nxt;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    start_legal = 1'b0;
    if ((num_bf_i != 4'd0) && (num_bf_i <= MaxBf)) begin
      start_legal = 1'b1;
    end
  end

  // issue_valid_o is registered and is high exactly in ISSUE, so ready is
  // only looked at while an operation is actually presented.
  assign handshake  = issue_valid_o & issue_ready_i;

  // The final butterfly is the one on lane count-1; lane never advances past
  // it, so a 3-bit lane register is enough for up to 8 butterflies.
  assign last_bf    = ({1'b0, lane_q} == (count_q - 4'd1));
  assign lane_nxt   = lane_q + 3'd1;
  // Twiddle index wraps silently modulo 2^TwIdxW.
  assign tw_idx_nxt = tw_idx_q + stride_q;

  // Sequencer FSM. All outputs are registered alongside the state so they
  // change only on clock edges and hold steady across a stalled handshake.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side reads the pre-edge value regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= StIdle;
      mode_q        <= 1'b0;
      count_q       <= 4'd0;
      stride_q      <= '0;
      lane_q        <= 3'd0;
      tw_idx_q      <= '0;
      issue_valid_o <= 1'b0;
      a_sel_o       <= 3'd0;
      b_sel_o       <= 3'd0;
      d_sel_o       <= 3'd0;
      op_o          <= OpNone;
      tw_idx_o      <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      // Pulses default low; only the transitions below raise them.
      done_o <= 1'b0;
      err_o  <= 1'b0;

      if (clear_i) begin
        // Abort wins over start and over a same-cycle handshake; the
        // sequence is dropped without a done pulse.
        state         <= StIdle;
        lane_q        <= 3'd0;
        issue_valid_o <= 1'b0;
        a_sel_o       <= 3'd0;
        b_sel_o       <= 3'd0;
        d_sel_o       <= 3'd0;
        op_o          <= OpNone;
        busy_o        <= 1'b0;
      end else begin
        unique case (state)
          StIdle: begin
            if (start_i) begin
              if (start_legal) begin
                state         <= StIssue;
                mode_q        <= mode_i;
                count_q       <= num_bf_i;
                stride_q      <= tw_stride_i;
                lane_q        <= 3'd0;
                tw_idx_q      <= tw_base_i;
                issue_valid_o <= 1'b1;
                a_sel_o       <= 3'd0;
                b_sel_o       <= 3'd0;
                d_sel_o       <= 3'd0;
                op_o          <= mode_i ? OpGs : OpCt;
                tw_idx_o      <= tw_base_i;
                busy_o        <= 1'b1;
              end else begin
                err_o <= 1'b1;
              end
            end
          end

          StIssue: begin
            // start_i is deliberately not examined here.
            if (handshake) begin
              if (last_bf) begin
                state         <= StDone;
                issue_valid_o <= 1'b0;
                op_o          <= OpNone;
                done_o        <= 1'b1;
              end else begin
                lane_q   <= lane_nxt;
                tw_idx_q <= tw_idx_nxt;
                a_sel_o  <= lane_nxt;
                b_sel_o  <= lane_nxt;
                d_sel_o  <= lane_nxt;
                tw_idx_o <= tw_idx_nxt;
                op_o     <= mode_q ? OpGs : OpCt;
              end
            end
          end

          StDone: begin
            state  <= StIdle;
            lane_q <= 3'd0;
            busy_o <= 1'b0;
          end

          default: begin
            state         <= StIdle;
            issue_valid_o <= 1'b0;
            op_o          <= OpNone;
            busy_o        <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef OTBN_PQ_BF_SEQ_STALL_CNT_EN
  // Stall counter: counts every cycle an operation is presented but not
  // accepted, saturates instead of wrapping, and restarts from zero at each
  // accepted start so it reflects only the current sequence.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_o <= 16'd0;
    end else if ((state == StIdle) && start_i && start_legal && !clear_i) begin
      stall_cnt_o <= 16'd0;
    end else if (issue_valid_o && !issue_ready_i && (stall_cnt_o != 16'hFFFF)) begin
      stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_otbn_pq_bf_seq.sv
// -----------------------------------------------------------------------------
// tb_otbn_pq_bf_seq
//
// Directed self-checking bench for otbn_pq_bf_seq. Inputs are driven 1 ns
// after each rising clock edge and outputs are sampled there too, so every
// observation reflects the state written by the preceding edge.
// -----------------------------------------------------------------------------
module tb_otbn_pq_bf_seq;

  localparam int TwIdxW = 8;

  logic              clk_i;
  logic              rst_ni;
  logic              start_i;
  logic              mode_i;
  logic [3:0]        num_bf_i;
  logic [TwIdxW-1:0] tw_base_i;
  logic [TwIdxW-1:0] tw_stride_i;
  logic              clear_i;
  logic              issue_valid_o;
  logic              issue_ready_i;
  logic [2:0]        a_sel_o;
  logic [2:0]        b_sel_o;
  logic [2:0]        d_sel_o;
  logic [7:0]        op_o;
  logic [TwIdxW-1:0] tw_idx_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
`ifdef OTBN_PQ_BF_SEQ_STALL_CNT_EN
  logic [15:0]       stall_cnt_o;
`endif

  int tests_run;
  int tests_failed;

  otbn_pq_bf_seq #(
    .TwIdxW  (TwIdxW),
    .NumLanes(8)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .mode_i       (mode_i),
    .num_bf_i     (num_bf_i),
    .tw_base_i    (tw_base_i),
    .tw_stride_i  (tw_stride_i),
    .clear_i      (clear_i),
    .issue_valid_o(issue_valid_o),
    .issue_ready_i(issue_ready_i),
    .a_sel_o      (a_sel_o),
    .b_sel_o      (b_sel_o),
    .d_sel_o      (d_sel_o),
    .op_o         (op_o),
    .tw_idx_o     (tw_idx_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
`ifdef OTBN_PQ_BF_SEQ_STALL_CNT_EN
    ,
    .stall_cnt_o  (stall_cnt_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Full view of one presented butterfly.
  task automatic check_issue(input string tag, input logic [2:0] lane,
                             input logic [7:0] op, input logic [7:0] tw);
    check({tag, " valid"}, 32'(issue_valid_o), 32'd1);
    check({tag, " a_sel"}, 32'(a_sel_o), 32'(lane));
    check({tag, " b_sel"}, 32'(b_sel_o), 32'(lane));
    check({tag, " d_sel"}, 32'(d_sel_o), 32'(lane));
    check({tag, " op"},    32'(op_o),    32'(op));
    check({tag, " tw"},    32'(tw_idx_o), 32'(tw));
    check({tag, " busy"},  32'(busy_o),  32'd1);
    check({tag, " done"},  32'(done_o),  32'd0);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_ni        = 1'b0;
    start_i       = 1'b0;
    mode_i        = 1'b0;
    num_bf_i      = 4'd0;
    tw_base_i     = 8'h00;
    tw_stride_i   = 8'h00;
    clear_i       = 1'b0;
    issue_ready_i = 1'b0;

    // ---- Reset state ----
    #12;
    check("rst valid", 32'(issue_valid_o), 32'd0);
    check("rst sel",   32'({a_sel_o, b_sel_o, d_sel_o}), 32'd0);
    check("rst op",    32'(op_o), 32'd0);
    check("rst tw",    32'(tw_idx_o), 32'd0);
    check("rst flags", 32'({busy_o, done_o, err_o}), 32'd0);
`ifdef OTBN_PQ_BF_SEQ_STALL_CNT_EN
    check("rst stall", 32'(stall_cnt_o), 32'd0);
`endif
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    tick();

    // ---- CT, 8 butterflies, base 0, stride 1, ready high ----
    start_i = 1'b1; mode_i = 1'b0; num_bf_i = 4'd8;
    tw_base_i = 8'h00; tw_stride_i = 8'h01; issue_ready_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_issue($sformatf("ct lane%0d", i), 3'(i), 8'h34, 8'(i));
      tick();
    end
    // Ninth edge after start: done pulse.
    check("ct done",       32'(done_o), 32'd1);
    check("ct done valid", 32'(issue_valid_o), 32'd0);
    check("ct done op",    32'(op_o), 32'd0);
    check("ct done busy",  32'(busy_o), 32'd1);
    tick();
    check("ct idle done",  32'(done_o), 32'd0);
    check("ct idle busy",  32'(busy_o), 32'd0);
    tick();

    // ---- GS, 3 butterflies, base FE: twiddle wraps; start ignored mid-run ----
    start_i = 1'b1; mode_i = 1'b1; num_bf_i = 4'd3;
    tw_base_i = 8'hFE; tw_stride_i = 8'h01;
    tick();
    // A fresh CT start while busy must have no effect.
    mode_i = 1'b0; num_bf_i = 4'd8; tw_base_i = 8'h40;
    check_issue("gs lane0", 3'd0, 8'h92, 8'hFE);
    tick();
    start_i = 1'b0;
    check_issue("gs lane1", 3'd1, 8'h92, 8'hFF);
    tick();
    check_issue("gs lane2", 3'd2, 8'h92, 8'h00);
    tick();
    check("gs done",  32'(done_o), 32'd1);
    tick();
    check("gs done once", 32'(done_o), 32'd0);
    check("gs idle valid", 32'(issue_valid_o), 32'd0);
    tick();
    check("gs no restart", 32'({issue_valid_o, busy_o, done_o}), 32'd0);

    // ---- Backpressure: ready low for 3 cycles on lane 2 ----
    start_i = 1'b1; mode_i = 1'b0; num_bf_i = 4'd4;
    tw_base_i = 8'h10; tw_stride_i = 8'h04; issue_ready_i = 1'b1;
    tick();
    start_i = 1'b0;
    check_issue("bp lane0", 3'd0, 8'h34, 8'h10);
    tick();
    check_issue("bp lane1", 3'd1, 8'h34, 8'h14);
    tick();
    check_issue("bp lane2", 3'd2, 8'h34, 8'h18);
    issue_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_issue($sformatf("bp hold%0d", i), 3'd2, 8'h34, 8'h18);
    end
`ifdef OTBN_PQ_BF_SEQ_STALL_CNT_EN
    check("bp stall cnt", 32'(stall_cnt_o), 32'd3);
`endif
    issue_ready_i = 1'b1;
    tick();
    check_issue("bp lane3", 3'd3, 8'h34, 8'h1C);
    tick();
    check("bp done", 32'(done_o), 32'd1);
`ifdef OTBN_PQ_BF_SEQ_STALL_CNT_EN
    check("bp stall final", 32'(stall_cnt_o), 32'd3);
`endif
    tick();
    tick();

    // ---- Illegal starts: num_bf 0 then 9 ----
    start_i = 1'b1; num_bf_i = 4'd0;
    tick();
    start_i = 1'b0;
    check("err0 pulse", 32'(err_o), 32'd1);
    check("err0 busy",  32'({busy_o, issue_valid_o}), 32'd0);
    tick();
    check("err0 end",   32'(err_o), 32'd0);
    start_i = 1'b1; num_bf_i = 4'd9;
    tick();
    start_i = 1'b0;
    check("err9 pulse", 32'(err_o), 32'd1);
    check("err9 busy",  32'({busy_o, issue_valid_o}), 32'd0);
    tick();
    check("err9 end",   32'({err_o, busy_o}), 32'd0);

    // ---- Clear at lane 4 together with ready ----
    start_i = 1'b1; mode_i = 1'b0; num_bf_i = 4'd8;
    tw_base_i = 8'h00; tw_stride_i = 8'h01; issue_ready_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_issue("clr lane4", 3'd4, 8'h34, 8'h04);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("clr valid", 32'(issue_valid_o), 32'd0);
    check("clr busy",  32'(busy_o), 32'd0);
    check("clr op",    32'(op_o), 32'd0);
    check("clr done",  32'(done_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("clr quiet%0d", i),
            32'({issue_valid_o, busy_o, done_o}), 32'd0);
    end

    // ---- Reset asserted at lane 5 ----
    start_i = 1'b1; mode_i = 1'b1; num_bf_i = 4'd8;
    tw_base_i = 8'h20; tw_stride_i = 8'h02;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_issue("rst lane5", 3'd5, 8'h92, 8'h2A);
    rst_ni = 1'b0;
    #1;
    check("arst valid", 32'(issue_valid_o), 32'd0);
    check("arst sel",   32'({a_sel_o, b_sel_o, d_sel_o}), 32'd0);
    check("arst op",    32'(op_o), 32'd0);
    check("arst tw",    32'(tw_idx_o), 32'd0);
    check("arst flags", 32'({busy_o, done_o, err_o}), 32'd0);
    tick();
    rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("arst quiet%0d", i),
            32'({issue_valid_o, busy_o, done_o}), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/otbn_pq_bf_seq.md
OTBN_PQ_BF_SEQ -- requirements
Module: otbn_pq_bf_seq

Interface
REQ-001 The block SHALL have parameter TwIdxW, default 8, giving the twiddle-index width.
REQ-002 The block SHALL have parameter NumLanes, default 8, giving the 32-bit lanes per 256-bit WDR; only the value 8 is supported.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-004 The block SHALL have port rst_ni, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 The block SHALL have port start_i, input, 1 bit: a one-cycle pulse that launches a butterfly sequence.
REQ-006 The block SHALL have port mode_i, input, 1 bit: 0 = Cooley-Tukey (CT), 1 = Gentleman-Sande (GS); sampled at start.
REQ-007 The block SHALL have port num_bf_i, input, 4 bits: butterflies to issue, 1..8; sampled at start.
REQ-008 The block SHALL have port tw_base_i, input, TwIdxW bits: first twiddle index; sampled at start.
REQ-009 The block SHALL have port tw_stride_i, input, TwIdxW bits: twiddle-index increment per butterfly; sampled at start.
REQ-010 The block SHALL have port clear_i, input, 1 bit: synchronous abort.
REQ-011 The block SHALL have port issue_valid_o, output, 1 bit: an ALU operation is presented.
REQ-012 The block SHALL have port issue_ready_i, input, 1 bit: the writeback stage accepts the operation.
REQ-013 The block SHALL have port a_sel_o, b_sel_o and d_sel_o, output, 3 bits each: operand_a, operand_b and destination lane selects.
REQ-014 The block SHALL have port op_o, output, 8 bits: the ALU op vector.
REQ-015 The block SHALL have port tw_idx_o, output, TwIdxW bits: twiddle-ROM index for the current butterfly.
REQ-016 The block SHALL have port busy_o, output, 1 bit: a sequence is in progress.
REQ-017 The block SHALL have port done_o, output, 1 bit: a one-cycle pulse when the sequence completes.
REQ-018 The block SHALL have port err_o, output, 1 bit: a one-cycle pulse when the start request is illegal.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE and DONE.
REQ-020 IDLE SHALL move to ISSUE when start_i=1 and num_bf_i is in 1..8; it SHALL latch mode, count, base and stride, set lane=0 and tw_idx=tw_base_i.
REQ-021 When start_i=1 in IDLE with num_bf_i=0 or num_bf_i>8, the block SHALL stay in IDLE and pulse err_o for 1 cycle.
REQ-022 In ISSUE, issue_valid_o SHALL be 1; a_sel_o, b_sel_o and d_sel_o SHALL equal lane.
REQ-023 In ISSUE, op_o SHALL be 8'h34 in CT mode and 8'h92 in GS mode; in any other state op_o SHALL be 8'h00.
REQ-024 Outputs SHALL hold stable while issue_valid_o=1 and issue_ready_i=0.
REQ-025 On a handshake (valid and ready), lane SHALL increment and tw_idx SHALL become tw_idx+stride, modulo 2^TwIdxW (wrap with no error).
REQ-026 The handshake on the final butterfly (lane = count-1) SHALL move the FSM to DONE.
REQ-027 DONE SHALL pulse done_o for 1 cycle and return to IDLE next cycle.
REQ-028 Latency SHALL be: first issue_valid_o in the cycle after start_i; with ready held high, done_o at start+count+1.
REQ-029 busy_o SHALL be 1 in ISSUE and DONE.
REQ-030 start_i SHALL be ignored while not in IDLE.
REQ-031 clear_i SHALL force IDLE next cycle from any state, with no done_o; clear_i has priority over start_i and over the handshake in the same cycle.
REQ-032 issue_ready_i SHALL be ignored when issue_valid_o=0.

Reset
REQ-033 Asserting rst_ni low SHALL, asynchronously, put the FSM in IDLE and zero lane, tw_idx and all latched fields.
REQ-034 Reset values of all outputs SHALL be 0: issue_valid_o, busy_o, done_o, err_o, selects, op_o, tw_idx_o (and stall_cnt_o when present).
REQ-035 Reset asserted mid-sequence SHALL abandon the sequence with no done_o after release.

Configuration
REQ-036 With macro OTBN_PQ_BF_SEQ_STALL_CNT_EN defined, the block SHALL add output stall_cnt_o, 16 bits, counting cycles with issue_valid_o=1 and issue_ready_i=0, saturating at 16'hFFFF and cleared at each accepted start.
REQ-037 Without OTBN_PQ_BF_SEQ_STALL_CNT_EN, neither the port nor the counter SHALL exist; all other behaviour is identical.

Verification
REQ-038 CT mode, num_bf=8, base=0, stride=1, ready always high -> 8 issues, lanes 0..7, tw_idx 0..7, op 8'h34, done_o at cycle 9 after start.
REQ-039 GS mode, num_bf=3, base=8'hFE, stride=1 -> tw_idx FE, FF, 00 (wrap), op 8'h92, done_o once.
REQ-040 Ready low for 3 cycles on lane 2 -> outputs frozen at lane 2; stall_cnt_o=3 when the macro is defined.
REQ-041 start with num_bf=0, then start with num_bf=9 -> err_o pulses twice, busy_o stays 0.
REQ-042 clear_i at lane 4, same cycle as ready=1 -> IDLE next cycle, no done_o, lane 5 never issued.
REQ-043 rst_ni low at lane 5 -> all outputs 0 immediately; no done_o after release.
